// File: rtl/fll_i2s_word_phase_det.sv
// Word-level phase detector between the external I2S master bit clock and the
// local bit clock; raises speed-up/slow-down interrupts with hysteresis.
module fll_i2s_word_phase_det #(
  parameter int unsigned BITS_PER_WORD = 32,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned THRESHOLD     = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 bitclk_master_i,
  input  logic                 bitclk_local_i,
  output logic                 Interrupt_speedup_o,
  output logic                 Interrupt_slowdown_o,
  output logic                 master_wordcnt_is_ahead_o,
  output logic                 local_wordcnt_is_ahead_o,
  output logic [CNT_WIDTH-1:0] word_diff_o
);

  localparam int unsigned BIT_W    = (BITS_PER_WORD > 2) ? $clog2(BITS_PER_WORD) : 1;
  localparam int unsigned LAST_BIT = BITS_PER_WORD - 1;
  localparam int          TH       = int'(THRESHOLD);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_SPEEDUP  = 2'd1,
    ST_SLOWDOWN = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] m_sync;
  logic [SYNC_STAGES-1:0] l_sync;
  logic                   m_prev;
  logic                   l_prev;
  logic                   m_pulse_c;
  logic                   l_pulse_c;

  logic [BIT_W-1:0]       m_bit;
  logic [BIT_W-1:0]       l_bit;
  logic [CNT_WIDTH-1:0]   m_word;
  logic [CNT_WIDTH-1:0]   l_word;
  logic [CNT_WIDTH-1:0]   diff_c;

  state_t                 state;
  state_t                 state_nxt;
  int                     diff_int;

  // Bit-clock synchronizers; these keep running through clear and disable.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      m_sync <= '0;
      l_sync <= '0;
      m_prev <= 1'b0;
      l_prev <= 1'b0;
    end else begin
      m_sync <= {m_sync[SYNC_STAGES-2:0], bitclk_master_i};
      l_sync <= {l_sync[SYNC_STAGES-2:0], bitclk_local_i};
      m_prev <= m_sync[SYNC_STAGES-1];
      l_prev <= l_sync[SYNC_STAGES-1];
    end
  end

  assign m_pulse_c = m_sync[SYNC_STAGES-1] & ~m_prev;
  assign l_pulse_c = l_sync[SYNC_STAGES-1] & ~l_prev;

  // Bit and word counters for both sides.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      m_bit  <= '0;
      l_bit  <= '0;
      m_word <= '0;
      l_word <= '0;
    end else if (clear_i) begin
      m_bit  <= '0;
      l_bit  <= '0;
      m_word <= '0;
      l_word <= '0;
    end else if (enable_i) begin
      if (m_pulse_c) begin
        if (m_bit == BIT_W'(LAST_BIT)) begin
          m_bit  <= '0;
          m_word <= m_word + CNT_WIDTH'(1);
        end else begin
          m_bit <= m_bit + BIT_W'(1);
        end
      end
      if (l_pulse_c) begin
        if (l_bit == BIT_W'(LAST_BIT)) begin
          l_bit  <= '0;
          l_word <= l_word + CNT_WIDTH'(1);
        end else begin
          l_bit <= l_bit + BIT_W'(1);
        end
      end
    end
  end

  // Modular subtraction keeps the signed difference valid across counter wrap.
  assign diff_c = m_word - l_word;

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      word_diff_o               <= '0;
      master_wordcnt_is_ahead_o <= 1'b0;
      local_wordcnt_is_ahead_o  <= 1'b0;
    end else if (clear_i) begin
      word_diff_o               <= '0;
      master_wordcnt_is_ahead_o <= 1'b0;
      local_wordcnt_is_ahead_o  <= 1'b0;
    end else begin
      word_diff_o               <= diff_c;
      master_wordcnt_is_ahead_o <= ~diff_c[CNT_WIDTH-1] & (|diff_c);
      local_wordcnt_is_ahead_o  <= diff_c[CNT_WIDTH-1];
    end
  end

  assign diff_int = int'($signed(word_diff_o));

  // Hysteresis FSM: enter on |diff| >= THRESHOLD, leave once diff returns to zero.
  always_comb begin
    state_nxt = state;
    if (clear_i || !enable_i) begin
      state_nxt = ST_LOCKED;
    end else begin
      case (state)
        ST_LOCKED: begin
          if (diff_int >= TH)       state_nxt = ST_SPEEDUP;
          else if (diff_int <= -TH) state_nxt = ST_SLOWDOWN;
        end
        ST_SPEEDUP:  if (diff_int <= 0) state_nxt = ST_LOCKED;
        ST_SLOWDOWN: if (diff_int >= 0) state_nxt = ST_LOCKED;
        default:     state_nxt = ST_LOCKED;
      endcase
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      state                <= ST_LOCKED;
      Interrupt_speedup_o  <= 1'b0;
      Interrupt_slowdown_o <= 1'b0;
    end else begin
      state                <= state_nxt;
      Interrupt_speedup_o  <= (state_nxt == ST_SPEEDUP);
      Interrupt_slowdown_o <= (state_nxt == ST_SLOWDOWN);
    end
  end

endmodule

// File: tb/tb_fll_i2s_word_phase_det.sv
// Randomized bench for fll_i2s_word_phase_det against a word-count reference model.
module tb_fll_i2s_word_phase_det;

  localparam int BPW = 32;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       bm;
  logic       bl;
  logic       int_su;
  logic       int_sd;
  logic       m_ahead;
  logic       l_ahead;
  logic [7:0] diff;
  logic [11:0] obs;

  int vecs = 0;
  int miss = 0;

  // Reference model: counted edges per side and hysteresis state (0 locked, 1 up, 2 down).
  int m_edges = 0;
  int l_edges = 0;
  int st = 0;

  fll_i2s_word_phase_det dut (
    .WBs_CLK_i                 (clk),
    .WBs_RST_i                 (rst_n),
    .enable_i                  (en),
    .clear_i                   (clr),
    .bitclk_master_i           (bm),
    .bitclk_local_i            (bl),
    .Interrupt_speedup_o       (int_su),
    .Interrupt_slowdown_o      (int_sd),
    .master_wordcnt_is_ahead_o (m_ahead),
    .local_wordcnt_is_ahead_o  (l_ahead),
    .word_diff_o               (diff)
  );

  assign obs = {int_su, int_sd, m_ahead, l_ahead, diff};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int model_diff();
    logic [7:0] w;
    w = 8'(m_edges / BPW - l_edges / BPW);
    return int'($signed(w));
  endfunction

  function automatic logic [11:0] exp_vec();
    int d;
    d = model_diff();
    return {st == 1, st == 2, d > 0, d < 0, 8'(d)};
  endfunction

  function automatic void model_step();
    int d;
    d = model_diff();
    if (!en) st = 0;
    else case (st)
      0: if (d >= 2) st = 1; else if (d <= -2) st = 2;
      1: if (d <= 0) st = 0;
      default: if (d >= 0) st = 0;
    endcase
  endfunction

  task automatic drive_edge(input bit m, input bit l, input int hi, input int lo);
    if (m) bm = 1'b1;
    if (l) bl = 1'b1;
    repeat (hi) @(negedge clk);
    bm = 1'b0;
    bl = 1'b0;
    repeat (lo) @(negedge clk);
    if (en) begin
      if (m) m_edges++;
      if (l) l_edges++;
    end
    model_step();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_edges = 0;
    l_edges = 0;
    st = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bm = ~bm;
      if (i % 3 == 0) bl = ~bl;
      @(negedge clk);
      vecs++;
      if (obs !== 12'h000) begin
        miss++;
        $display("FAIL reset_hold: got %h expected 000", obs);
      end
    end
    bm = 1'b0;
    bl = 1'b0;
    settle(4);
    rst_n = 1'b1;
    m_edges = 0;
    l_edges = 0;
    st = 0;
    settle(6);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++;
      $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_matched();
    for (int i = 0; i < 10 * BPW; i++) begin
      drive_edge(1, 1, $urandom_range(2, 4), $urandom_range(2, 4));
      vecs++;
      if (obs[11:10] !== 2'b00 || !(diff inside {8'h00, 8'h01, 8'hff})) begin
        miss++;
        $display("FAIL matched_edge%0d: got %h expected diff within +-1, no irq", i, obs);
      end
    end
    settle(2);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++;
      $display("FAIL matched_final: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_speedup();
    for (int i = 0; i < 63; i++) begin
      drive_edge(1, 0, 2, 2);
      if (i == 31) begin
        settle(2);
        vecs++;
        if (obs !== exp_vec() || m_ahead !== 1'b1) begin
          miss++;
          $display("FAIL speedup_word1: got %h expected %h", obs, exp_vec());
        end
      end
    end
    // 64th edge: interrupt must appear exactly 4 cycles after first sampling.
    bm = 1'b1;
    settle(4);
    m_edges++;
    vecs++;
    if (int_su !== 1'b0) begin
      miss++;
      $display("FAIL speedup_early: got %b expected 0", int_su);
    end
    @(negedge clk);
    model_step();
    vecs++;
    if (obs !== exp_vec() || int_su !== 1'b1 || diff !== 8'd2) begin
      miss++;
      $display("FAIL speedup_latency: got %h expected %h", obs, exp_vec());
    end
    bm = 1'b0;
    settle(2);
    for (int i = 0; i < BPW; i++) drive_edge(0, 1, 2, 2);
    settle(2);
    vecs++;
    if (obs !== exp_vec() || int_su !== 1'b1 || diff !== 8'd1) begin
      miss++;
      $display("FAIL speedup_hold: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < BPW; i++) drive_edge(0, 1, 2, 2);
    settle(2);
    vecs++;
    if (obs !== exp_vec() || int_su !== 1'b0 || diff !== 8'd0) begin
      miss++;
      $display("FAIL speedup_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_slowdown();
    for (int i = 0; i < 2 * BPW; i++) begin
      drive_edge(0, 1, $urandom_range(2, 3), 2);
      vecs++;
      if (int_su !== 1'b0) begin
        miss++;
        $display("FAIL slowdown_no_speedup%0d: got %b expected 0", i, int_su);
      end
    end
    settle(2);
    vecs++;
    if (obs !== exp_vec() || diff !== 8'hfe || int_sd !== 1'b1) begin
      miss++;
      $display("FAIL slowdown_final: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    bit side;
    do_clear();
    settle(2);
    for (int i = 0; i < 240; i++) begin
      side = ($urandom_range(0, 99) < ((i < 120) ? 75 : 25));
      drive_edge(side, !side, $urandom_range(2, 4), $urandom_range(2, 4));
      settle(2);
      vecs++;
      if (obs !== exp_vec()) begin
        miss++;
        $display("FAIL random_edge%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clear_enable();
    do_clear();
    settle(2);
    for (int i = 0; i < 2 * BPW; i++) drive_edge(1, 0, 2, 2);
    settle(2);
    vecs++;
    if (obs !== exp_vec() || int_su !== 1'b1) begin
      miss++;
      $display("FAIL clear_pre: got %h expected %h", obs, exp_vec());
    end
    do_clear();
    vecs++;
    if (obs !== 12'h000) begin
      miss++;
      $display("FAIL clear_pulse: got %h expected 000", obs);
    end
    for (int i = 0; i < 2 * BPW; i++) drive_edge(1, 0, 2, 2);
    settle(2);
    en = 1'b0;
    model_step();
    settle(3);
    vecs++;
    if (obs !== exp_vec() || int_su !== 1'b0) begin
      miss++;
      $display("FAIL disable_irq: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 100; i++) drive_edge(1, 0, $urandom_range(2, 4), 2);
    settle(2);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++;
      $display("FAIL disable_hold: got %h expected %h", obs, exp_vec());
    end
    // Re-enable while master is high: the already-seen edge must not count.
    bm = 1'b1;
    settle(6);
    en = 1'b1;
    model_step();
    settle(4);
    bm = 1'b0;
    settle(2);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++;
      $display("FAIL reenable: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < BPW; i++) begin
      drive_edge(1, 0, 2, 2);
      settle(1);
      vecs++;
      if (obs !== exp_vec()) begin
        miss++;
        $display("FAIL reenable_edge%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs !== 12'h000) begin
      miss++;
      $display("FAIL async_reset: got %h expected 000", obs);
    end
    m_edges = 0;
    l_edges = 0;
    st = 0;
    @(negedge clk);
    rst_n = 1'b1;
    settle(4);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++;
      $display("FAIL async_reset_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_clear();
    settle(2);
    for (int i = 0; i < BPW; i++) drive_edge(1, 0, 2, 2);
    for (int i = 0; i < 300 * BPW; i++) begin
      drive_edge(1, 1, 2, 2);
      if (obs[11:10] !== 2'b00) begin
        vecs++;
        miss++;
        $display("FAIL wrap_irq_edge%0d: got %b expected 00", i, obs[11:10]);
      end
    end
    vecs++;
    settle(2);
    if (obs !== exp_vec() || diff !== 8'd1) begin
      miss++;
      $display("FAIL wrap_final: got %h expected %h", obs, exp_vec());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    bm    = 1'b0;
    bl    = 1'b0;
    test_reset();
    test_matched();
    test_speedup();
    test_slowdown();
    test_random();
    test_clear_enable();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/fll_i2s_word_phase_det.md
# fll_i2s_word_phase_det

Upstream stage of the FLL interrupt path in the S3_FLL_I2S design. It samples the external I2S master bit clock and the locally generated bit clock as data in the fabric clock domain. It counts completed words on each and tracks their signed word-count difference. It drives the speed-up/slow-down interrupts to the M4 with hysteresis, plus the word-count-ahead debug flags.

## Interface
- BITS_PER_WORD, 32: bit-clock rising edges per word; 2..256.
- CNT_WIDTH, 8: word counter and difference width; 3..16.
- THRESHOLD, 2: word difference magnitude that raises an interrupt; 1..2^(CNT_WIDTH-1)-1.
- SYNC_STAGES, 2: synchronizer flops per bit clock; ≥2.
- WBs_CLK_i  in  1  fabric clock. Must be ≥4× the faster bit clock.
- WBs_RST_i  in  1  asynchronous, active-low reset (0 = reset).
- enable_i  in  1  detector enable, synchronous.
- clear_i  in  1  synchronous clear of counters and state.
- bitclk_master_i  in  1  external master bit clock, asynchronous.
- bitclk_local_i  in  1  local bit clock, asynchronous.
- Interrupt_speedup_o  out  1  level; local clock too slow.
- Interrupt_slowdown_o  out  1  level; local clock too fast.
- master_wordcnt_is_ahead_o  out  1  registered, word_diff_o > 0.
- local_wordcnt_is_ahead_o  out  1  registered, word_diff_o < 0.
- word_diff_o  out  CNT_WIDTH  registered signed (master − local) word difference.

## Operation
- **Synchronizer.** Each bit clock passes through a SYNC_STAGES flop chain. A following prev flop holds the last synchronized value. The edge pulse is sync_last & ~prev, one WBs_CLK_i cycle wide.
- **Bit counter.** Each side has one, counting 0..BITS_PER_WORD−1 on its edge pulse. An edge at count BITS_PER_WORD−1 sets the count to 0 and increments that side's word counter. The word counter is CNT_WIDTH bits and wraps modulo 2^CNT_WIDTH.
- **Difference.** word_diff_o = master_word − local_word, modulo 2^CNT_WIDTH, interpreted as two's complement. It stays correct across counter wrap while |difference| < 2^(CNT_WIDTH-1).
- **Simultaneous word completions.** Both word counters increment in the same cycle, so the difference is unchanged.
- **State machine.** States: LOCKED (reset), SPEEDUP, SLOWDOWN.
  - LOCKED → SPEEDUP when diff ≥ THRESHOLD.
  - LOCKED → SLOWDOWN when diff ≤ −THRESHOLD.
  - SPEEDUP → LOCKED when diff ≤ 0.
  - SLOWDOWN → LOCKED when diff ≥ 0.
  - There is no direct SPEEDUP↔SLOWDOWN transition.
  - Interrupt_speedup_o = (state == SPEEDUP); Interrupt_slowdown_o = (state == SLOWDOWN). Both are registered state decodes.
- **enable_i = 0.**
  - Edge pulses are ignored and the counters hold.
  - State is forced to LOCKED, so both interrupts are 0.
  - word_diff_o and the ahead flags keep tracking the held counters.
  - The synchronizer and prev flops keep running, so no spurious edge occurs on re-enable.
- **clear_i = 1.** Has priority over edge pulses and over enable_i.
  - Bit counters, word counters and state go to zero/LOCKED.
  - The synchronizer and prev flops are unaffected.
  - An edge pulse coincident with clear is discarded.
- **Reset (WBs_RST_i = 0).** All flops clear asynchronously, synchronizers included.
  - After release, a bit clock that is already high produces one edge pulse once it has propagated through the chain. That edge is counted.
  - Reset asserted mid-operation clears everything immediately. Interrupts drop in the same cycle, asynchronously.

## Timing
- Reset value of every output: 0.
- Latency, in WBs_CLK_i edges:
  - A bit-clock rising edge first sampled high at WBs_CLK_i edge k gives an edge pulse during cycle k+SYNC_STAGES−1.
  - The counters update at edge k+SYNC_STAGES.
  - word_diff_o and the ahead flags update at edge k+SYNC_STAGES+1.
  - The state and interrupts update at edge k+SYNC_STAGES+2.
  - With defaults, the interrupt changes 4 cycles after first sampling.
- The difference changes by at most ±1 per cycle.
- Pulses of a bit clock, high or low, shorter than 2 WBs_CLK_i periods are not guaranteed to be counted.

## Test plan
- **Reset.** Hold WBs_RST_i = 0 with both bit clocks toggling → all outputs 0. Release with both clocks low → word_diff_o = 0 and no interrupts.
- **Matched clocks.** Both bit clocks at the same rate for 10 words, defaults → word_diff_o stays in {−1, 0, +1} with no interrupts. After both finish exactly 320 edges, word_diff_o = 0.
- **Speed-up and hysteresis.**
  - 64 master edges, local idle → master_wordcnt_is_ahead_o = 1 after edge 32. Interrupt_speedup_o = 1 exactly 4 cycles after the 64th edge is sampled, with word_diff_o = 2.
  - Then 32 local edges → word_diff_o = 1 and the interrupt is held.
  - 32 more local edges → word_diff_o = 0 and the interrupt falls.
- **Slow-down mirror.** 64 local edges, master idle → word_diff_o = −2 (0xFE) and Interrupt_slowdown_o = 1. Interrupt_speedup_o stays 0 throughout.
- **Wrap-around.** Master 301 words, local 300 words, interleaved → both word counters wrap past 255. word_diff_o = 1 and no interrupt at any point after the first word.
- **Clear and enable.**
  - In SPEEDUP, pulse clear_i for 1 cycle → interrupt = 0 and word_diff_o = 0 on the next edge.
  - With enable_i = 0, 100 master edges → counters unchanged and interrupts 0.
  - Re-enable with bitclk_master_i high → no extra edge counted.
